// File: rtl/ov7670_fb_writer.sv
// Packs the capture-stage byte stream into RGB565 pixels, optionally decimates 2x2,
// and writes them to a framebuffer with frame-relative linear addresses.
//   state  | meaning
//   IDLE   | disarmed, waiting for enable while vsync is high
//   SYNC   | armed, waiting for the vsync falling edge that starts a frame
//   ACTIVE | frame in progress, pixels written to the framebuffer
module ov7670_fb_writer #(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480,
    parameter int DECIMATE = 1,
    parameter int ADDR_W   = 17
) (
    input  logic              pclk_12,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              vsync,
    input  logic              hsync,
    input  logic              vde,
    input  logic [7:0]        din,
    output logic              fb_we,
    output logic [ADDR_W-1:0] fb_addr,
    output logic [15:0]       fb_data,
    output logic              frame_done,
    output logic              line_err,
    output logic              busy
);

    localparam int PX_W      = $clog2(H_ACTIVE + 1);
    localparam int LN_W      = $clog2(V_ACTIVE + 1);
    localparam int FB_PIXELS = (H_ACTIVE * V_ACTIVE) >> (2 * DECIMATE);
    localparam logic [ADDR_W-1:0] MAX_ADDR = ADDR_W'(FB_PIXELS - 1);
    localparam logic [PX_W-1:0]   PX_MAX   = PX_W'(H_ACTIVE);
    localparam logic [LN_W-1:0]   LN_MAX   = LN_W'(V_ACTIVE);

    typedef enum logic [1:0] {IDLE, SYNC, ACTIVE} state_t;

    state_t            state;
    logic              vsync_q;
    logic              vde_q;
    logic              phase;
    logic [7:0]        hi_byte;
    logic [PX_W-1:0]   px;
    logic [LN_W-1:0]   ln;
    logic [ADDR_W-1:0] addr;
    logic              addr_full;

    logic vde_e, vsync_rise, vsync_fall, in_range, dec_ok;

    // A byte only counts while the capture stage reports the line as active.
    assign vde_e      = vde & hsync;
    assign vsync_rise = vsync & ~vsync_q;
    assign vsync_fall = ~vsync & vsync_q;
    assign in_range   = (px < PX_MAX) && (ln < LN_MAX);
    assign dec_ok     = (DECIMATE == 0) || (!px[0] && !ln[0]);
    assign busy       = (state == ACTIVE);

    always_ff @(posedge pclk_12 or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            vsync_q    <= 1'b0;
            vde_q      <= 1'b0;
            phase      <= 1'b0;
            hi_byte    <= '0;
            px         <= '0;
            ln         <= '0;
            addr       <= '0;
            addr_full  <= 1'b0;
            fb_we      <= 1'b0;
            fb_addr    <= '0;
            fb_data    <= '0;
            frame_done <= 1'b0;
            line_err   <= 1'b0;
        end else begin
            vsync_q    <= vsync;
            fb_we      <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable && vsync) state <= SYNC;
                end
                SYNC: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (vsync_fall) begin
                        state     <= ACTIVE;
                        addr      <= '0;
                        addr_full <= 1'b0;
                        px        <= '0;
                        ln        <= '0;
                        phase     <= 1'b0;
                        vde_q     <= 1'b0;
                        line_err  <= 1'b0;
                    end
                end
                ACTIVE: begin
                    // Frame end wins over any byte presented in the same cycle.
                    if (vsync_rise) begin
                        frame_done <= 1'b1;
                        state      <= enable ? SYNC : IDLE;
                        phase      <= 1'b0;
                        vde_q      <= 1'b0;
                    end else begin
                        vde_q <= vde_e;
                        if (vde_e) begin
                            if (!phase) begin
                                hi_byte <= din;
                                phase   <= 1'b1;
                            end else begin
                                phase <= 1'b0;
                                px    <= (px == PX_MAX) ? px : px + 1'b1;
                                if (!in_range) begin
                                    line_err <= 1'b1;
                                end else if (dec_ok) begin
                                    if (addr_full) begin
                                        line_err <= 1'b1;
                                    end else begin
                                        fb_we   <= 1'b1;
                                        fb_addr <= addr;
                                        fb_data <= {hi_byte, din};
                                        if (addr == MAX_ADDR) addr_full <= 1'b1;
                                        else                  addr      <= addr + 1'b1;
                                    end
                                end
                            end
                        end else begin
                            phase <= 1'b0;
                            if (phase) line_err <= 1'b1;
                            if (vde_q) begin
                                if (px != PX_MAX) line_err <= 1'b1;
                                px <= '0;
                                ln <= (ln == LN_MAX) ? ln : ln + 1'b1;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ov7670_fb_writer.sv
// Scoreboard bench: two writers (full-rate and 2x2 decimated) share one 4x2 stimulus stream.
module tb_ov7670_fb_writer;

    localparam int AW = 17;

    logic          pclk_12 = 1'b0;
    logic          reset_n, enable, vsync, hsync, vde;
    logic [7:0]    din;
    logic          fb_we0, fb_we1, frame_done0, frame_done1;
    logic          line_err0, line_err1, busy0, busy1;
    logic [AW-1:0] fb_addr0, fb_addr1;
    logic [15:0]   fb_data0, fb_data1;

    int checks   = 0;
    int failures = 0;
    logic [AW+15:0] q0[$];
    logic [AW+15:0] q1[$];

    always #5 pclk_12 = ~pclk_12;

    ov7670_fb_writer #(.H_ACTIVE(4), .V_ACTIVE(2), .DECIMATE(0), .ADDR_W(AW)) u_dut0 (
        .pclk_12(pclk_12), .reset_n(reset_n), .enable(enable), .vsync(vsync),
        .hsync(hsync), .vde(vde), .din(din), .fb_we(fb_we0), .fb_addr(fb_addr0),
        .fb_data(fb_data0), .frame_done(frame_done0), .line_err(line_err0), .busy(busy0));

    ov7670_fb_writer #(.H_ACTIVE(4), .V_ACTIVE(2), .DECIMATE(1), .ADDR_W(AW)) u_dut1 (
        .pclk_12(pclk_12), .reset_n(reset_n), .enable(enable), .vsync(vsync),
        .hsync(hsync), .vde(vde), .din(din), .fb_we(fb_we1), .fb_addr(fb_addr1),
        .fb_data(fb_data1), .frame_done(frame_done1), .line_err(line_err1), .busy(busy1));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor: every write strobe seen between edges is matched against the queue head.
    always @(negedge pclk_12) begin
        if (fb_we0 === 1'b1) begin
            if (q0.size() == 0) begin
                checks++; failures++;
                $display("FAIL wr0_unexpected actual=%0h expected=none", {fb_addr0, fb_data0});
            end else chk("wr0", {fb_addr0, fb_data0}, q0.pop_front());
        end
        if (fb_we1 === 1'b1) begin
            if (q1.size() == 0) begin
                checks++; failures++;
                $display("FAIL wr1_unexpected actual=%0h expected=none", {fb_addr1, fb_data1});
            end else chk("wr1", {fb_addr1, fb_data1}, q1.pop_front());
        end
    end

    task automatic step(input int n = 1);
        repeat (n) @(posedge pclk_12);
        #1;
    endtask

    task automatic exp0(input int a, input logic [15:0] d);
        q0.push_back({AW'(a), d});
    endtask

    task automatic exp1(input int a, input logic [15:0] d);
        q1.push_back({AW'(a), d});
    endtask

    task automatic send_line(input logic [7:0] start, input int n);
        for (int i = 0; i < n; i++) begin
            hsync = 1'b1; vde = 1'b1; din = start + 8'(i);
            step();
        end
        vde = 1'b0; hsync = 1'b0; din = 8'h00;
        step(2);
    endtask

    task automatic frame_start();
        vsync = 1'b1; step(2);
        vsync = 1'b0; step(2);
    endtask

    task automatic frame_end();
        vsync = 1'b1;
        step();
        chk("frame_done0_pulse", frame_done0, 1);
        chk("frame_done1_pulse", frame_done1, 1);
        chk("busy0_after_frame", busy0, 0);
        step();
        chk("frame_done0_single", frame_done0, 0);
        chk("frame_done1_single", frame_done1, 0);
    endtask

    task automatic queues_empty(input string tag);
        chk({tag, "_q0_left"}, q0.size(), 0);
        chk({tag, "_q1_left"}, q1.size(), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n = 1'b0; enable = 1'b0; vsync = 1'b0; hsync = 1'b0; vde = 1'b0; din = 8'h00;
        step(3);
        chk("rst_fb_we0", fb_we0, 0);       chk("rst_fb_we1", fb_we1, 0);
        chk("rst_fb_addr0", fb_addr0, 0);   chk("rst_fb_data0", fb_data0, 0);
        chk("rst_frame_done0", frame_done0, 0);
        chk("rst_line_err0", line_err0, 0); chk("rst_busy0", busy0, 0);
        chk("rst_busy1", busy1, 0);
        reset_n = 1'b1;
        step();

        // Nominal frame: 2 lines of 8 bytes 0x00..0x0F.
        enable = 1'b1;
        for (int i = 0; i < 8; i++) exp0(i, {8'(2*i), 8'(2*i+1)});
        exp1(0, 16'h0001); exp1(1, 16'h0405);
        frame_start();
        chk("t1_busy0", busy0, 1);
        send_line(8'h00, 8);
        send_line(8'h08, 8);
        frame_end();
        chk("t1_line_err0", line_err0, 0);
        chk("t1_line_err1", line_err1, 0);
        queues_empty("t1");

        // Short line, then a line with a dangling odd byte.
        exp0(0, 16'h1011); exp0(1, 16'h1213); exp0(2, 16'h1415);
        exp0(3, 16'h2021); exp0(4, 16'h2223); exp0(5, 16'h2425);
        exp1(0, 16'h1011); exp1(1, 16'h1415);
        frame_start();
        send_line(8'h10, 6);
        chk("t3_line_err0_short", line_err0, 1);
        chk("t3_line_err1_short", line_err1, 1);
        send_line(8'h20, 7);
        frame_end();
        chk("t3_line_err0_sticky", line_err0, 1);
        queues_empty("t3");

        // Enable dropped mid-frame: frame completes, the following frame is ignored.
        for (int i = 0; i < 8; i++) exp0(i, {8'(8'h40 + 2*i), 8'(8'h41 + 2*i)});
        exp1(0, 16'h4041); exp1(1, 16'h4445);
        frame_start();
        chk("t5_line_err0_cleared", line_err0, 0);
        chk("t5_line_err1_cleared", line_err1, 0);
        send_line(8'h40, 8);
        enable = 1'b0;
        send_line(8'h48, 8);
        frame_end();
        queues_empty("t5");
        frame_start();
        send_line(8'h58, 8);
        chk("t5_idle_busy0", busy0, 0);
        chk("t5_idle_busy1", busy1, 0);

        // Enable raised mid-frame: nothing until a full vsync high->low.
        enable = 1'b1;
        send_line(8'h70, 8);
        chk("t4_wait_busy0", busy0, 0);
        for (int i = 0; i < 8; i++) exp0(i, {8'(8'h30 + 2*i), 8'(8'h31 + 2*i)});
        exp1(0, 16'h3031); exp1(1, 16'h3435);
        frame_start();
        send_line(8'h30, 8);
        send_line(8'h38, 8);
        frame_end();
        queues_empty("t4");

        // Reset between the two bytes of a pixel.
        frame_start();
        hsync = 1'b1; vde = 1'b1; din = 8'h50;
        step();
        din = 8'h51;
        #2 reset_n = 1'b0;
        #1;
        chk("t6_fb_we0", fb_we0, 0);       chk("t6_fb_data0", fb_data0, 0);
        chk("t6_fb_addr0", fb_addr0, 0);   chk("t6_busy0", busy0, 0);
        chk("t6_fb_data1", fb_data1, 0);   chk("t6_busy1", busy1, 0);
        vde = 1'b0; hsync = 1'b0;
        step(2);
        reset_n = 1'b1;
        step();
        send_line(8'h58, 8);
        chk("t6_idle_busy0", busy0, 0);
        queues_empty("t6a");

        // Reset while a write strobe is up: it must drop without waiting for a clock.
        frame_start();
        hsync = 1'b1; vde = 1'b1; din = 8'h60;
        step();
        din = 8'h61;
        step();
        chk("t6_write_up0", {fb_we0, fb_data0}, {1'b1, 16'h6061});
        chk("t6_write_up1", {fb_we1, fb_data1}, {1'b1, 16'h6061});
        #1 reset_n = 1'b0;
        #1;
        chk("t6_async_we0", fb_we0, 0);
        chk("t6_async_we1", fb_we1, 0);
        vde = 1'b0; hsync = 1'b0;
        step(2);
        reset_n = 1'b1;
        step(2);
        queues_empty("t6b");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ov7670_fb_writer.md
Name: ov7670_fb_writer

Overview:
- Downstream of the OV7670 capture stage, in the 12 MHz pixel clock domain.
- Consumes the capture stage's byte stream (dout, vde, hsync) plus sensor vsync.
- Pairs bytes into 16-bit RGB565 pixels and optionally decimates 2x2 (VGA to QVGA).
- Issues framebuffer block-RAM writes with a frame-relative linear address, plus frame/line status.

Parameters:
H_ACTIVE, 640, input pixels per line (bytes per line = 2*H_ACTIVE)
V_ACTIVE, 480, input lines per frame
DECIMATE, 1, 1 = keep even pixel of even line (2x2 decimation); 0 = keep all
ADDR_W, 17, framebuffer address width; must hold (H_ACTIVE*V_ACTIVE)>>(2*DECIMATE)

Ports:
pclk_12  input  1  pixel clock, all logic on rising edge
reset_n  input  1  asynchronous active-low reset
enable  input  1  arm capture; level, synchronous to pclk_12
vsync  input  1  sensor vertical sync, high = blanking between frames
hsync  input  1  capture-stage hsync (high while line active)
vde  input  1  byte valid from capture stage
din  input  8  byte from capture stage, valid when vde=1
fb_we  output  1  framebuffer write strobe
fb_addr  output  ADDR_W  framebuffer write address
fb_data  output  16  pixel {first byte, second byte}
frame_done  output  1  one-cycle pulse, frame completed
line_err  output  1  sticky: line length mismatch or overflow in current frame
busy  output  1  high in ACTIVE state

Behaviour:
- Reset (async, reset_n=0): state=IDLE; all outputs 0; px, ln, byte phase, addr counter cleared.
- States:
  - IDLE: enable=1 and vsync=1 -> SYNC. Never start mid-frame.
  - SYNC: vsync falling edge (registered compare) -> ACTIVE; clear addr counter, ln, line_err. enable=0 -> IDLE.
  - ACTIVE: vsync rising edge -> pulse frame_done next cycle; then -> SYNC if enable=1, else IDLE. enable dropping mid-frame does not abort; frame completes.
- Byte phase:
  - Toggles on each vde=1 cycle in ACTIVE; phase 0 byte latched as high byte.
  - Forced to 0 whenever vde=0; a dangling odd byte is discarded and sets line_err.
- Pixel completes on the phase-1 byte; px increments (saturates at H_ACTIVE).
- Line end = vde 1->0 transition:
  - if px != H_ACTIVE, set line_err;
  - then px=0, ln+1 (saturates at V_ACTIVE).
- Pixel kept when px < H_ACTIVE and ln < V_ACTIVE, and either DECIMATE=0 or (px[0]==0 and ln[0]==0). Pixels/lines beyond limits are dropped and set line_err.
- Kept pixel timing:
  - fb_we=1 for exactly one cycle, registered: the cycle after the phase-1 byte is sampled.
  - fb_data = {high byte, din} and fb_addr = current addr counter, both valid with fb_we.
  - addr counter then increments.
  - Latency: byte in -> write out = 1 cycle.
- Address arithmetic: unsigned ADDR_W bits. Maximum address (H_ACTIVE*V_ACTIVE>>(2*DECIMATE))-1, never exceeded: writes past it are suppressed and set line_err.
- fb_we=0 outside ACTIVE; vde ignored in IDLE/SYNC.
- hsync is used only as a qualifier:
  - vde=1 while hsync=0 is treated as vde=0;
  - hsync 1->0 with vde still 1 counts as line end.
- line_err clears only on SYNC->ACTIVE or reset; frame_done still pulses when line_err=1.
- Simultaneous vsync rise and vde=1: the frame ends first; that byte is dropped.
- Reset mid-frame: immediate return to IDLE; any in-flight write is lost, and fb_we deasserts asynchronously.

Test Plan:
- H_ACTIVE=4, V_ACTIVE=2, DECIMATE=0; enable=1, vsync pulse, 2 lines of 8 bytes 0x00..0x0F -> 8 writes, addr 0..7, fb_data 0x0001,0x0203,...,0x0E0F; frame_done one pulse after vsync rise; line_err=0.
- DECIMATE=1, same frame -> 2 writes: addr0=0x0001, addr1=0x0405; line 1 writes nothing; line_err=0.
- Short line of 6 bytes then a 7-byte line (DECIMATE=0) -> line_err=1 after the first line end; the odd byte is not written; frame_done still pulses.
- enable asserted while vsync=0 mid-frame -> no writes until the next full vsync high->low; first write at addr 0.
- enable dropped mid-frame -> the remaining frame writes complete, frame_done pulses, state IDLE, busy=0; the next frame produces no writes.
- reset_n asserted between phase-0 and phase-1 bytes -> all outputs 0 immediately, no write emitted; after release, stays IDLE until enable and vsync.
